// File: rtl/sqrt_iter_param.sv
// rtl/sqrt_iter_param.sv - multi-cycle restoring integer square root, one root bit per clock
// Optional round-to-nearest result when SQRT_ROUND_EN is defined.
module sqrt_iter_param #(
    parameter int IN_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic [IN_W-1:0]     mag,
    output logic                busy,
    output logic                done,
    output logic [IN_W/2-1:0]   sqrt,
    output logic [IN_W/2:0]     rem
);
    localparam int OUT_W = IN_W / 2;
    localparam int CNT_W = $clog2(OUT_W);

    generate
        if ((IN_W % 2) != 0 || IN_W < 4) begin : g_bad_width
            $error("sqrt_iter_param: IN_W must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t             state;
    state_t             state_n;
    logic [IN_W-1:0]    op;
    logic [OUT_W+1:0]   part;
    logic [OUT_W-1:0]   root;
    logic [CNT_W-1:0]   cnt;
    logic               fin;
    logic               accept;
    logic [OUT_W+1:0]   shifted;
    logic [OUT_W+1:0]   trial;
    logic [OUT_W+1:0]   part_nx;
    logic [OUT_W-1:0]   root_nx;
    logic [OUT_W-1:0]   sqrt_fin;

    assign accept = go && (state != CALC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (go) state_n = CALC;
            CALC:    if (fin) state_n = DONE;
            DONE:    state_n = go ? CALC : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // One restoring step: bring down two operand bits and try subtracting {root,01}.
    always_comb begin
        shifted = {part[OUT_W-1:0], op[IN_W-1 -: 2]};
        trial   = {root, 2'b01};
        if (shifted >= trial) begin
            part_nx = shifted - trial;
            root_nx = {root[OUT_W-2:0], 1'b1};
        end else begin
            part_nx = shifted;
            root_nx = {root[OUT_W-2:0], 1'b0};
        end
    end

`ifdef SQRT_ROUND_EN
    // Remainder above root means mag lies past (root+0.5)^2; saturate at all-ones.
    assign sqrt_fin = ((part > {2'b00, root}) && (root != {OUT_W{1'b1}})) ?
                      root + OUT_W'(1) : root;
`else
    assign sqrt_fin = root;
`endif

    // The edge after the last iteration only publishes the result, giving OUT_W+1 cycles per op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op   <= '0;
            part <= '0;
            root <= '0;
            cnt  <= '0;
            fin  <= 1'b0;
            sqrt <= '0;
            rem  <= '0;
        end else begin
            if (accept) begin
                op   <= mag;
                part <= '0;
                root <= '0;
                cnt  <= CNT_W'(OUT_W - 1);
                fin  <= 1'b0;
            end else if (state == CALC && !fin) begin
                op   <= op << 2;
                part <= part_nx;
                root <= root_nx;
                cnt  <= cnt - CNT_W'(1);
                if (cnt == '0) fin <= 1'b1;
            end
            if (state == CALC && fin) begin
                sqrt <= sqrt_fin;
                rem  <= part[OUT_W:0];
            end
        end
    end
endmodule
